clk_div_prog: RTL



---
 rtl/clk_div_prog_if.sv | 12 +
 rtl/clk_div_prog.sv | 54 +++++
 2 files changed

// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: control/status bundle for the programmable clock divider
interface clk_div_prog_if #(
  parameter int DIV_W = 8
);
  logic             i_en;
  logic [DIV_W-1:0] i_div;
  logic             o_clk;
  logic             o_tick;
  logic [DIV_W-1:0] o_div_cur;
  modport master (output i_en, i_div, input o_clk, o_tick, o_div_cur);
  modport slave  (input i_en, i_div, output o_clk, o_tick, o_div_cur);
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable glitch-free clock divider with tick pulse
module clk_div_prog #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 10
) (
  input  logic           i_clk,
  input  logic           i_rst,
  clk_div_prog_if.slave  bus
);
  localparam int               DEF_I   = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEF_I);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic             r_clk, r_tick;
  logic             w_clk_nxt, w_tick_nxt, w_bound;
  logic [DIV_W-1:0] w_neff, w_high;
  assign w_neff  = (bus.i_div < DIV_W'(2)) ? DIV_W'(2) : bus.i_div;
  assign w_bound = (r_state == RUN) && (r_cnt == r_div - DIV_W'(1));
  // ratio and run/stop decisions are only taken at a period boundary or from IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + DIV_W'(1);
    w_div_nxt   = r_div;
    w_tick_nxt  = 1'b0;
    if (r_state == IDLE || w_bound) begin
      w_cnt_nxt   = '0;
      w_state_nxt = bus.i_en ? RUN : IDLE;
      w_div_nxt   = bus.i_en ? w_neff : r_div;
      w_tick_nxt  = bus.i_en;
    end
  end
  assign w_high    = w_div_nxt - (w_div_nxt >> 1);
  assign w_clk_nxt = (w_state_nxt == RUN) && (w_cnt_nxt < w_high);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= DEF_DIV;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_div_nxt;
      r_clk   <= w_clk_nxt;
      r_tick  <= w_tick_nxt;
    end
  end
  assign bus.o_clk     = r_clk;
  assign bus.o_tick    = r_tick;
  assign bus.o_div_cur = r_div;
endmodule
